// File: rtl/uart_tx_if.sv
// Byte handshake into the UART transmitter: fabric logic is master, uart_tx is slave.
interface uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register and back-to-back frames.
// Define UART_TX_PARITY_EN to insert an even/odd parity bit after D7 (8E1/8O1).
module uart_tx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_tx_if.slave bus,
    output logic     tx,
    output logic     tx_busy,
    output logic     tx_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);

    generate
        if (CLKS_PER_BIT < 2 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : gBadParam
            $error("uart_tx: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bitIdx;
    logic [7:0]    shiftReg;
    logic [7:0]    holdData;
    logic          holdFull;
    logic          readyR;
`ifdef UART_TX_PARITY_EN
    logic          parBit;
`endif

    logic bitEnd, stopLast, accept, frameEnd, loadNow;

    assign bus.tx_ready = readyR;
    assign bitEnd   = (cnt == CW'(CLKS_PER_BIT - 1));
    assign stopLast = (bitIdx == 3'(STOP_BITS - 1));
    assign accept   = bus.tx_valid && readyR;
    assign frameEnd = (state == STOP) && bitEnd && stopLast;
    // Hold drains either from IDLE or straight out of the last stop period, so frames abut.
    assign loadNow  = holdFull && ((state == IDLE) || frameEnd);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
            holdData <= '0;
            holdFull <= 1'b0;
            readyR   <= 1'b1;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parBit   <= 1'b0;
`endif
        end else begin
            tx_done <= frameEnd;

            // accept needs readyR, which implies hold is empty, so it never collides with loadNow
            if (accept) begin
                holdFull <= 1'b1;
                holdData <= bus.tx_data;
                readyR   <= 1'b0;
            end else if (loadNow) begin
                holdFull <= 1'b0;
                readyR   <= 1'b1;
            end

            cnt <= bitEnd ? '0 : cnt + 1'b1;

            if (loadNow) begin
                shiftReg <= holdData;
`ifdef UART_TX_PARITY_EN
                parBit   <= (PARITY_ODD != 0) ? ~^holdData : ^holdData;
`endif
                state    <= START;
                tx       <= 1'b0;
                tx_busy  <= 1'b1;
                cnt      <= '0;
                bitIdx   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        tx      <= 1'b1;
                        tx_busy <= 1'b0;
                        cnt     <= '0;
                    end
                    START: if (bitEnd) begin
                        state <= DATA;
                        tx    <= shiftReg[0];
                    end
                    DATA: if (bitEnd) begin
                        if (bitIdx == 3'd7) begin
                            bitIdx <= '0;
`ifdef UART_TX_PARITY_EN
                            state  <= PARITY;
                            tx     <= parBit;
`else
                            state  <= STOP;
                            tx     <= 1'b1;
`endif
                        end else begin
                            bitIdx   <= bitIdx + 3'd1;
                            shiftReg <= {1'b0, shiftReg[7:1]};
                            tx       <= shiftReg[1];
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: if (bitEnd) begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end
`endif
                    STOP: if (bitEnd) begin
                        if (stopLast) begin
                            state   <= IDLE;
                            tx_busy <= 1'b0;
                            bitIdx  <= '0;
                        end else begin
                            bitIdx <= bitIdx + 3'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
